// File: rtl/peripheral_ahb3_slave_mem.sv
// -----------------------------------------------------------------------------
// peripheral_ahb3_slave_mem
//   AHB3-Lite slave memory used as the bus target of the AHB master BFM.
//   Word-organised storage with byte-lane write enables, a configurable number
//   of wait states per OKAY data phase, and the two-cycle ERROR response for
//   out-of-range, oversized or misaligned transfers. Contents are not reset.
//
// Parameters
//   HADDR_SIZE  address width
//   HDATA_SIZE  data width (32 or 64)
//   MEM_DEPTH   number of HDATA_SIZE-bit words
//   WAIT_STATES wait cycles before each OKAY data phase completes (0..15)
//
// Ports
//   HRESETn    in   async active-low reset
//   HCLK       in   clock
//   HSEL       in   slave select
//   HADDR      in   byte address
//   HWDATA     in   write data (data phase)
//   HRDATA     out  read data (zero outside a completing data phase)
//   HWRITE     in   1 = write
//   HSIZE      in   transfer size
//   HBURST     in   burst type (not used)
//   HPROT      in   protection (not used)
//   HTRANS     in   IDLE/BUSY/NONSEQ/SEQ
//   HMASTLOCK  in   lock (not used)
//   HREADY     in   bus-level ready
//   HREADYOUT  out  slave ready
//   HRESP      out  0 = OKAY, 1 = ERROR
// -----------------------------------------------------------------------------
module peripheral_ahb3_slave_mem #(
  parameter int HADDR_SIZE  = 16,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HRESETn,
  input  logic                  HCLK,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int unsigned BYTES     = HDATA_SIZE / 8;
  localparam int unsigned LB        = $clog2(BYTES);
  localparam int unsigned IW        = $clog2(MEM_DEPTH);
  localparam int unsigned DEPTH     = MEM_DEPTH;
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                  state, state_n, accept_next;
  logic [3:0]              cnt, cnt_n;
  logic [HADDR_SIZE-1:0]   addr_q;
  logic                    write_q;
  logic [2:0]              size_q;
  logic [HDATA_SIZE-1:0]   mem [MEM_DEPTH];

  logic                    sample, illegal;
  logic [31:0]             word_idx, span, lane_off, lane_cnt;
  logic [IW-1:0]           widx_q;
  logic [BYTES-1:0]        be;
  logic                    unused_ok;

  // HREADYOUT is low in WAIT/ERR1, so gating on it keeps the address
  // registers stable even if HREADY were mis-wired.
  assign sample = HSEL & HREADY & HTRANS[1] & HREADYOUT;

  always_comb begin
    word_idx = 32'(HADDR >> LB);
    span     = 32'd1 << HSIZE;
    illegal  = (word_idx >= DEPTH) || (span > BYTES) ||
               ((32'(HADDR) & (span - 32'd1)) != 32'd0);
  end

  assign accept_next = illegal ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_DATA);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      S_IDLE, S_DATA, S_ERR2: state_n = sample ? accept_next : S_IDLE;
      S_WAIT: begin
        if (cnt == WAIT_LAST) begin
          state_n = S_DATA;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      S_ERR1:  state_n = S_ERR2;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (sample) begin
        addr_q  <= HADDR;
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
    end
  end

  assign widx_q = addr_q[LB +: IW];

  always_comb begin
    be       = '0;
    lane_off = 32'(addr_q[LB-1:0]);
    lane_cnt = 32'd1 << size_q;
    for (int unsigned i = 0; i < BYTES; i++)
      be[i] = (i >= lane_off) && (i < lane_off + lane_cnt);
  end

  // The write lands on the edge that closes DATA; an async reset during the
  // data phase forces IDLE first, so the pending write is dropped.
  always_ff @(posedge HCLK) begin
    if (state == S_DATA && write_q) begin
      for (int unsigned i = 0; i < BYTES; i++)
        if (be[i]) mem[widx_q][8*i +: 8] <= HWDATA[8*i +: 8];
    end
  end

  assign HREADYOUT = !(state == S_WAIT || state == S_ERR1);
  assign HRESP     = (state == S_ERR1) || (state == S_ERR2);
  assign HRDATA    = (state == S_DATA) ? mem[widx_q] : '0;

  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, addr_q};

endmodule

// File: tb/tb_peripheral_ahb3_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_peripheral_ahb3_slave_mem
//   Directed bench for peripheral_ahb3_slave_mem. Three instances with
//   WAIT_STATES = 0, 2 and 3 share the bus signals; only one is selected at a
//   time and each sees its own HREADYOUT as HREADY. A pipelined master pushes
//   expected results (from a byte-lane memory model) to a scoreboard at
//   address-phase acceptance and pops them when the data phase completes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_peripheral_ahb3_slave_mem;

  logic        hclk    = 1'b0;
  logic        hresetn = 1'b0;
  logic [2:0]  hsel    = '0;
  logic [15:0] haddr   = '0;
  logic [31:0] hwdata  = '0;
  logic        hwrite  = 1'b0;
  logic [2:0]  hsize   = 3'd2;
  logic [2:0]  hburst  = '0;
  logic [3:0]  hprot   = 4'h3;
  logic [1:0]  htrans  = '0;
  logic        hmastlock = 1'b0;
  logic        rdy   [3];
  logic        rsp   [3];
  logic [31:0] rdata [3];

  int checks = 0;
  int errors = 0;
  int unsigned ws [3] = '{0, 2, 3};

  logic [31:0] mdl [3][256];

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic        err;
    logic [31:0] rdata;
    int unsigned waits;
  } exp_t;
  exp_t sb[$];

  logic [15:0] q_addr[$];
  logic        q_wr[$];
  logic [2:0]  q_size[$];
  logic [31:0] q_wdata[$];
  logic        q_seq[$];

  always #5 hclk = ~hclk;

  peripheral_ahb3_slave_mem #(.HADDR_SIZE(16), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .HRESETn(hresetn), .HCLK(hclk), .HSEL(hsel[0]), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rdata[0]), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(rdy[0]), .HREADYOUT(rdy[0]), .HRESP(rsp[0]));

  peripheral_ahb3_slave_mem #(.HADDR_SIZE(16), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_ws2 (
    .HRESETn(hresetn), .HCLK(hclk), .HSEL(hsel[1]), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rdata[1]), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(rdy[1]), .HREADYOUT(rdy[1]), .HRESP(rsp[1]));

  peripheral_ahb3_slave_mem #(.HADDR_SIZE(16), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_ws3 (
    .HRESETn(hresetn), .HCLK(hclk), .HSEL(hsel[2]), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rdata[2]), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(rdy[2]), .HREADYOUT(rdy[2]), .HRESP(rsp[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic bad(input logic [15:0] a, input logic [2:0] s);
    int unsigned n;
    n = 32'd1 << s;
    return ((a >> 2) >= 16'd256) || (n > 4) || ((32'(a) % n) != 0);
  endfunction

  task automatic add(input logic [15:0] a, input logic w, input logic [2:0] s,
                     input logic [31:0] d, input logic seq);
    q_addr.push_back(a);
    q_wr.push_back(w);
    q_size.push_back(s);
    q_wdata.push_back(d);
    q_seq.push_back(seq);
  endtask

  // Pipelined master: address of beat ai overlaps the data phase of beat di.
  task automatic run(input int k, output int unsigned dcycles);
    int          n;
    int          ai;
    int          di;
    int unsigned wc;
    int unsigned guard;
    logic        wresp;
    logic [31:0] wrd;
    exp_t        e;
    n = q_addr.size();
    ai = 0; di = -1; wc = 0; guard = 0; wresp = 1'b0; wrd = '0; dcycles = 0;
    while ((ai < n || di >= 0) && guard < 300) begin
      guard++;
      hsel = '0;
      if (ai < n) begin
        hsel[k] = 1'b1;
        haddr   = q_addr[ai];
        hwrite  = q_wr[ai];
        hsize   = q_size[ai];
        htrans  = q_seq[ai] ? 2'b11 : 2'b10;
      end else begin
        htrans = 2'b00;
        hwrite = 1'b0;
      end
      hwdata = (di >= 0) ? q_wdata[di] : '0;
      @(negedge hclk);
      if (di >= 0) dcycles++;
      if (rdy[k]) begin
        if (di >= 0) begin
          e = sb.pop_front();
          chk($sformatf("waits[%0d@%h]", k, e.addr), wc, e.waits);
          chk($sformatf("wait_resp[%0d@%h]", k, e.addr), 32'(wresp), 32'(e.err));
          chk($sformatf("wait_rdata[%0d@%h]", k, e.addr), wrd, '0);
          chk($sformatf("resp[%0d@%h]", k, e.addr), 32'(rsp[k]), 32'(e.err));
          if (!e.wr || e.err)
            chk($sformatf("rdata[%0d@%h]", k, e.addr), rdata[k], e.rdata);
        end
        if (ai < n) begin
          e.addr  = q_addr[ai];
          e.wr    = q_wr[ai];
          e.err   = bad(q_addr[ai], q_size[ai]);
          e.waits = e.err ? 1 : ws[k];
          e.rdata = e.err ? '0 : mdl[k][q_addr[ai] >> 2];
          sb.push_back(e);
          if (e.wr && !e.err) begin
            for (int i = 0; i < 4; i++)
              if (i >= int'(q_addr[ai] % 4) && i < int'(q_addr[ai] % 4) + (1 << q_size[ai]))
                mdl[k][q_addr[ai] >> 2][8*i +: 8] = q_wdata[ai][8*i +: 8];
          end
          di = ai;
          ai++;
        end else begin
          di = -1;
        end
        wc = 0; wresp = 1'b0; wrd = '0;
      end else begin
        wc++;
        wresp = wresp | rsp[k];
        wrd   = wrd | rdata[k];
      end
      @(posedge hclk); #1;
    end
    checks++;
    assert (guard < 300) else begin
      errors++;
      $error("FAIL run_timeout[%0d]: observed %0d cycles expected < 300", k, guard);
    end
    chk($sformatf("sb_empty[%0d]", k), sb.size(), 0);
    sb.delete();
    q_addr.delete(); q_wr.delete(); q_size.delete(); q_wdata.delete(); q_seq.delete();
    hsel = '0; htrans = 2'b00; hwrite = 1'b0; hwdata = '0; hburst = 3'b000;
  endtask

  initial begin
    int unsigned dc;

    #12;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_readyout[%0d]", k), 32'(rdy[k]), 1);
      chk($sformatf("rst_resp[%0d]", k), 32'(rsp[k]), 0);
      chk($sformatf("rst_rdata[%0d]", k), rdata[k], '0);
    end
    @(negedge hclk); hresetn = 1'b1;
    @(posedge hclk); #1;

    // Zero wait states: word write then immediate read of the same word.
    add(16'h0010, 1'b1, 3'd2, 32'hDEAD_BEEF, 1'b0);
    add(16'h0010, 1'b0, 3'd2, '0, 1'b0);
    run(0, dc);
    chk("ws0_data_cycles", dc, 2);

    // Byte and halfword lane writes.
    add(16'h0010, 1'b1, 3'd2, 32'h1122_3344, 1'b0);
    add(16'h0013, 1'b1, 3'd0, 32'hAA00_0000, 1'b0);
    add(16'h0010, 1'b0, 3'd2, '0, 1'b0);
    add(16'h0012, 1'b1, 3'd1, 32'h5566_0000, 1'b0);
    add(16'h0010, 1'b0, 3'd2, '0, 1'b0);
    run(0, dc);
    chk("byte_lane_model", mdl[0][4], 32'h5566_3344);

    // Illegal accesses: out of range, misaligned halfword, oversized.
    add(16'h0000, 1'b1, 3'd2, 32'hCAFE_F00D, 1'b0);
    add(16'h0400, 1'b1, 3'd2, 32'h0BAD_0BAD, 1'b0);
    add(16'h0000, 1'b0, 3'd2, '0, 1'b0);
    add(16'h0001, 1'b1, 3'd1, 32'hFFFF_FFFF, 1'b0);
    add(16'h0000, 1'b1, 3'd3, 32'h1234_5678, 1'b0);
    add(16'h0000, 1'b0, 3'd2, '0, 1'b0);
    add(16'h03FC, 1'b0, 3'd2, '0, 1'b0);
    run(0, dc);

    // Two wait states: INCR4 write and readback, plus an ERROR that stays 2 cycles.
    hburst = 3'b011;
    for (int i = 0; i < 4; i++) add(16'h0020 + 16'(4*i), 1'b1, 3'd2, 32'(i + 1), i != 0);
    run(1, dc);
    chk("incr4_wr_cycles", dc, 12);
    hburst = 3'b011;
    for (int i = 0; i < 4; i++) add(16'h0020 + 16'(4*i), 1'b0, 3'd2, '0, i != 0);
    run(1, dc);
    chk("incr4_rd_cycles", dc, 12);
    add(16'h0400, 1'b1, 3'd2, 32'h0BAD_0BAD, 1'b0);
    add(16'h0024, 1'b0, 3'd2, '0, 1'b0);
    run(1, dc);

    // Three wait states: reset during the second wait cycle drops the write.
    add(16'h0008, 1'b1, 3'd2, 32'h5A5A_1234, 1'b0);
    run(2, dc);
    hsel = 3'b100; haddr = 16'h0008; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
    @(posedge hclk); #1;
    hsel = '0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'hFFFF_FFFF;
    @(posedge hclk); #1;
    chk("wait2_readyout", 32'(rdy[2]), 0);
    hresetn = 1'b0;
    #1;
    chk("arst_readyout", 32'(rdy[2]), 1);
    chk("arst_resp", 32'(rsp[2]), 0);
    chk("arst_rdata", rdata[2], '0);
    @(negedge hclk); hresetn = 1'b1;
    @(posedge hclk); #1;
    hwdata = '0;
    add(16'h0008, 1'b0, 3'd2, '0, 1'b0);
    run(2, dc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/peripheral_ahb3_slave_mem.md
# peripheral_ahb3_slave_mem

Synthesizable AMBA3 AHB-Lite slave memory that sits directly downstream of the AHB3-Lite master BFM in the peripheral test benches and serves as its bus target. It accepts single and burst transfers of every legal size, inserts a configurable number of wait states per data phase, and returns the two-cycle ERROR response on illegal accesses. Storage is a word-organised array with byte-lane write enables.

## Interface
- HADDR_SIZE, 16: address width.
- HDATA_SIZE, 32: data width (32 or 64).
- MEM_DEPTH, 256: number of HDATA_SIZE-bit words.
- WAIT_STATES, 0: wait cycles (HREADYOUT low) inserted before each OKAY data phase completes; 0..15.

Ports:
- HRESETn  in  1  reset, asynchronous, active-low.
- HCLK  in  1  clock.
- HSEL  in  1  slave select.
- HADDR  in  HADDR_SIZE  byte address.
- HWDATA  in  HDATA_SIZE  write data (data phase).
- HRDATA  out  HDATA_SIZE  read data.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size (0 = byte … 7 = 1024 bit).
- HBURST  in  3  burst type; informational only.
- HPROT  in  4  ignored.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HMASTLOCK  in  1  ignored.
- HREADY  in  1  bus-level ready (from mux).
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

## Operation
- Address phase sampled on a rising HCLK edge when HSEL & HREADY & HTRANS[1]. Registers addr_q, write_q, size_q.
- IDLE/BUSY sampled with HSEL & HREADY, or HSEL low: no access; next cycle HREADYOUT=1, HRESP=0.
- Legality check at sampling: error if word index HADDR/(HDATA_SIZE/8) >= MEM_DEPTH, or 2^HSIZE > HDATA_SIZE/8, or HADDR mod 2^HSIZE != 0.
- States: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: legal transfer sampled -> WAIT if WAIT_STATES>0 else DATA; illegal -> ERR1.
  - WAIT: HREADYOUT=0, counter counts WAIT_STATES cycles -> DATA.
  - DATA: HREADYOUT=1, HRESP=0; transfer completes this cycle. A new sampled transfer goes to WAIT/DATA/ERR1 as from IDLE; otherwise IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2. ERR2: HREADYOUT=1, HRESP=1; samples next transfer like IDLE.
- Write: byte enables = 2^size_q lanes starting at lane addr_q mod (HDATA_SIZE/8); HWDATA lanes committed on the edge ending DATA. Other lanes unchanged.
- Read: in DATA, HRDATA = mem[addr_q word] (full word, all lanes); HRDATA = 0 in all other states.
- Errored transfers never modify memory. Memory contents are not reset.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, wait counter 0. Reset mid-WAIT/DATA drops the pending write; outputs return to reset values asynchronously.
- OKAY latency: data phase lasts WAIT_STATES+1 cycles; zero-wait sustains one beat per cycle across bursts.
- ERROR always exactly 2 cycles regardless of WAIT_STATES.
- Write followed immediately by read of same word: read DATA returns the newly written value (write commits on the edge that samples the read address).
- HREADY low from another slave: no sampling; state held.

## Test plan
- WAIT_STATES=0: write 0xDEADBEEF to 0x0010 (word), then read 0x0010 -> HRDATA=0xDEADBEEF, HRESP=0, each data phase 1 cycle.
- Preload 0x11223344 at 0x0010; byte write 0xAA to 0x0013 (lane 3) -> readback 0xAA223344.
- WAIT_STATES=2: INCR4 word write 0x1,0x2,0x3,0x4 from 0x0020 -> HREADYOUT low 2 cycles per beat, 12 data-phase cycles total; INCR4 readback returns 0x1..0x4.
- MEM_DEPTH=256: word write to 0x0400 -> HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1; read of 0x0000 unchanged.
- Halfword write at 0x0001 -> two-cycle ERROR; 64-bit size on 32-bit bus -> ERROR.
- WAIT_STATES=3: assert HRESETn low during second WAIT cycle of write to 0x0008 -> HREADYOUT=1 immediately; after reset, read 0x0008 returns prior contents.
